// File: rtl/demux1an_rr_gather_pkg.sv
// -----------------------------------------------------------------------------
// demux1an_rr_gather_pkg
// Shared definitions for the round-robin 1-to-N demultiplexer:
//   - default data width and lane count
//   - mode encodings (direct / gathered)
//   - onehot() helper that turns a lane index into a lane mask
// -----------------------------------------------------------------------------
package demux1an_rr_gather_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_CH_DEF = 4;

  // Largest supported lane count and the index width that covers it.
  localparam int MAX_CH    = 16;
  localparam int MAX_PTR_W = 4;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_GATHER = 1'b1
  } mode_e;

  // Lane mask with only bit idx set; callers size-cast the result down to
  // their own lane count.
  function automatic logic [MAX_CH-1:0] onehot(input logic [MAX_PTR_W-1:0] idx);
    return {{(MAX_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/demux_lane_ptr.sv
// -----------------------------------------------------------------------------
// demux_lane_ptr
// Wrapping lane pointer for the round-robin demultiplexer.
//   clk_2f   : clock, rising edge
//   reset_L  : asynchronous active-low reset (pointer -> 0)
//   sync     : realign; pointer becomes 0, or 1 if a word is accepted this
//              cycle (that word is taken as lane 0)
//   flush    : end of a partial group; pointer returns to 0
//   advance  : a word is accepted this cycle
//   lane_ptr : lane the next accepted word goes to
//   is_last  : lane_ptr currently points at lane NUM_CH-1
// -----------------------------------------------------------------------------
module demux_lane_ptr #(
  parameter  int NUM_CH = 4,
  localparam int PTR_W  = $clog2(NUM_CH)
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  logic             sync,
  input  logic             flush,
  input  logic             advance,
  output logic [PTR_W-1:0] lane_ptr,
  output logic             is_last
);

  assign is_last = (lane_ptr == PTR_W'(NUM_CH - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      lane_ptr <= '0;
    end else if (sync) begin
      // The word on a sync cycle occupies lane 0, so the next one goes to 1.
      lane_ptr <= advance ? PTR_W'(1) : '0;
    end else if (flush) begin
      lane_ptr <= '0;
    end else if (advance) begin
      lane_ptr <= is_last ? '0 : lane_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/demux1an_rr_gather.sv
// -----------------------------------------------------------------------------
// demux1an_rr_gather
// Round-robin 1-to-NUM_CH demultiplexer with direct and gathered modes.
//   clk_2f   : sole clock, rising edge
//   reset_L  : asynchronous active-low reset
//   valid    : data_in carries a word this cycle
//   data_in  : input word
//   mode     : 0 = direct (each lane loads on its turn),
//              1 = gathered (lanes load together once a group is complete)
//   sync     : realign pointer to lane 0, discarding any partial group
//   flush    : gathered mode only, emit the partial group now
//   data_out : lane i at bits [i*DATA_W +: DATA_W]; held between loads
//   validout : per-lane one-cycle load pulse
//   lane_ptr : lane the next valid word will go to
// A change of mode behaves like sync on that cycle, and the new mode already
// governs the word presented with it.
// -----------------------------------------------------------------------------
module demux1an_rr_gather
  import demux1an_rr_gather_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int PTR_W  = $clog2(NUM_CH)
) (
  input  logic                     clk_2f,
  input  logic                     reset_L,
  input  logic                     valid,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     mode,
  input  logic                     sync,
  input  logic                     flush,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        validout,
  output logic [PTR_W-1:0]         lane_ptr
);

  // Staging holds lanes 0..NUM_CH-2; the last lane always takes data_in
  // directly because its word is what completes a group.
  logic [DATA_W-1:0] staging [NUM_CH-1];
  logic [NUM_CH-1:0] fill;
  logic              mode_q;

  logic              is_last;
  logic              sync_eff;
  logic              gathered;
  logic              flush_eff;
  logic [PTR_W-1:0]  cur_lane;
  logic              cur_last;
  logic [NUM_CH-1:0] fill_base;
  logic [NUM_CH-1:0] word_mask;
  logic [NUM_CH-1:0] out_mask;
  logic [NUM_CH-1:0] fill_nxt;
  logic [NUM_CH-2:0] stage_mask;
  logic [DATA_W-1:0] lane_src [NUM_CH];

  // A mode change realigns exactly like an explicit sync.
  assign sync_eff  = sync || (mode != mode_q);
  assign gathered  = (mode == MODE_GATHER);
  // sync wins over flush: the partial group is dropped, not emitted.
  assign flush_eff = gathered && flush && !sync_eff;

  // On a sync cycle the incoming word is lane 0 and earlier fills are gone.
  assign cur_lane  = sync_eff ? '0 : lane_ptr;
  assign cur_last  = !sync_eff && is_last;
  assign fill_base = sync_eff ? '0 : fill;
  assign word_mask = valid ? NUM_CH'(onehot(MAX_PTR_W'(cur_lane))) : '0;

  demux_lane_ptr #(
    .NUM_CH (NUM_CH)
  ) u_lane_ptr (
    .clk_2f   (clk_2f),
    .reset_L  (reset_L),
    .sync     (sync_eff),
    .flush    (flush_eff),
    .advance  (valid),
    .lane_ptr (lane_ptr),
    .is_last  (is_last)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    out_mask   = '0;
    fill_nxt   = '0;
    stage_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lane_src[i] = data_in;
    end
    for (int i = 0; i < NUM_CH - 1; i++) begin
      if (!word_mask[i]) begin
        lane_src[i] = staging[i];
      end
    end

    if (!gathered) begin
      out_mask = word_mask;
    end else if (valid && cur_last) begin
      // Last word of a group: every lane loads together.
      out_mask = '1;
    end else if (flush_eff) begin
      // Partial group: only lanes that hold a word (including this one) load.
      out_mask = fill_base | word_mask;
    end else begin
      stage_mask = word_mask[NUM_CH-2:0];
      fill_nxt   = fill_base | word_mask;
    end
  end

  // NOTE: the staging array is reset along with the other state so a flush
  // after reset can never expose stale words; it is small enough to be flops.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      data_out <= '0;
      validout <= '0;
      fill     <= '0;
      mode_q   <= MODE_DIRECT;
      for (int i = 0; i < NUM_CH - 1; i++) begin
        staging[i] <= '0;
      end
    end else begin
      mode_q   <= mode;
      validout <= out_mask;
      fill     <= fill_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (out_mask[i]) begin
          data_out[i*DATA_W +: DATA_W] <= lane_src[i];
        end
      end
      for (int i = 0; i < NUM_CH - 1; i++) begin
        if (stage_mask[i]) begin
          staging[i] <= data_in;
        end
      end
    end
  end

endmodule

// File: doc/demux1an_rr_gather.md
Name: demux1an_rr_gather

Overview:
- Parametrised 1-to-NUM_CH demultiplexer; successor to the fixed 8-bit 1-to-2 demux built from 4-bit halves.
- Distributes a valid-qualified input word stream round-robin across NUM_CH output lanes, on a single clock domain.
- Two modes:
  - Direct: each lane updates on its own turn.
  - Gathered: words are buffered until a full group is collected, then all lanes update together.
- Supports sync (pointer realign) and flush (emit partial group); sits in the Rx path ahead of the per-lane consumers.

Parameters:
- DATA_W, 8, width of one data word.
- NUM_CH, 4, number of output lanes; legal range 2..16.
- PTR_W, $clog2(NUM_CH), width of the lane pointer; derived, not overridden.

Ports:
- clk_2f  input  1  sole clock; all state updates on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- valid  input  1  data_in carries a word this cycle.
- data_in  input  DATA_W  input word.
- mode  input  1  0 = direct, 1 = gathered.
- sync  input  1  force lane pointer to 0; discard any partial group.
- flush  input  1  gathered mode only: emit the partial group now.
- data_out  output  NUM_CH*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- validout  output  NUM_CH  per-lane valid, one-cycle pulse.
- lane_ptr  output  PTR_W  lane that the next valid word will go to.

Behaviour:
- Reset (reset_L=0, async): data_out=0, validout=0, lane_ptr=0, staging regs=0, fill mask=0, mode_q=0.
- Pointer:
  - Advances by 1 per accepted word (valid=1).
  - Wraps from NUM_CH-1 to 0.
  - Holds when valid=0.
- Direct mode (mode_q=0):
  - On edge with valid=1: lane[lane_ptr] data_out <= data_in, validout <= onehot(lane_ptr).
  - Latency 1 cycle.
  - Other lanes hold their data; validout is 0 on cycles without valid.
- Gathered mode (mode_q=1):
  - Words for lanes 0..NUM_CH-2 go into staging[lane_ptr]; fill[lane_ptr] is set.
  - The word for lane NUM_CH-1 triggers a group load on that edge: data_out <= {data_in, staging[NUM_CH-2:0]}, validout <= all ones, fill <= 0.
  - Group latency is 1 cycle after the last word.
  - validout is 0 on every cycle that is not a group emit.
- Flush (gathered mode, flush=1):
  - Current-cycle word (if valid) joins the group first.
  - Every lane with fill=1 (including the current word's lane) loads its staged value; validout = that fill mask.
  - Unfilled lanes hold their data.
  - Pointer and fill reset to 0.
  - flush with empty fill and valid=0: no emit, validout=0.
  - flush in direct mode is ignored.
- Sync:
  - Pointer <= 0 and fill <= 0; staged data is discarded with no emit.
  - sync with valid=1: the word is treated as lane 0 and the pointer becomes 1 (NUM_CH≥2).
  - sync has priority over flush: a partial group is discarded, not emitted.
- Mode change:
  - mode is registered into mode_q.
  - When mode != mode_q, the cycle behaves as sync: partial group discarded, pointer to 0.
  - The new mode governs from that edge on; a word presented on the switch cycle is handled in the new mode as lane 0.
- Reset mid-group clears all state immediately; no residual validout.
- validout is never X; data_out changes only on cycles where some validout bit is 1.

Decomposition:
- Shared package:
  - DATA_W and NUM_CH defaults.
  - Mode encodings MODE_DIRECT=1'b0, MODE_GATHER=1'b1.
  - onehot helper function.
- One sub-module: demux_lane_ptr (wrapping counter with sync/advance/clear; outputs lane_ptr and is_last).
- Staging, fill mask and output registers stay in the top module.

Test Plan (DATA_W=8, NUM_CH=4):
- Direct mode: valid stream 0xA0,0xA1,0xA2,0xA3,0xA4 -> lanes 0,1,2,3,0 each load one cycle later; validout = 0001,0010,0100,1000,0001; lane_ptr wraps to 1.
- Gathered mode: 0x10..0x13 on consecutive cycles -> validout=0000 for 3 cycles, then 1111 with data_out=0x13121110; idle gaps between words do not change the result.
- Gathered mode: 0x20,0x21, then flush with valid=1 carrying 0x22 -> validout=0111, lanes 0..2 = 0x20,0x21,0x22, lane 3 holds its old value; lane_ptr=0.
- Gathered mode: 0x30,0x31, then sync with valid=1 carrying 0x40 -> no emit; 0x40 is staged at lane 0 and lane_ptr=1; three more words then emit a group with lane0=0x40.
- Switch mode 1->0 with two words staged -> no emit; lane_ptr=0; the next word goes to lane 0 as a direct pulse 0001.
- Assert reset_L low asynchronously mid-clock during a partial group -> all outputs 0 immediately; after release, the first word lands in lane 0.
